ks_adder_bist: RTL
==================

# ks_adder_bist

Built-in self-test engine for the Kogge-Stone adder macro. It generates operand vectors (four fixed corner cases, then LFSR pseudo-random vectors) and drives them into the adder's inputs. It samples the adder's sum and carry-out, compares them against an internal behavioural sum, and reports pass/fail, an error count and the first failing vector. It sits beside the adder in the user project area and is started from a logic-analyzer or Wishbone control bit.

## Interface

**Parameters**
- `WIDTH`, default 16: adder operand width, legal range 4..16.
- `NUM_VECTORS`, default 256: number of random vectors after the corner set, legal range 1..65535.
- `ADDER_LAT`, default 0: register stages inside the adder under test, legal range 0..3.
- `SEED`, default 32'hACE1_2024: LFSR reset value. A value of 0 is replaced by 1.

**Ports**
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle run request. Ignored while `busy`.
- `a_o`, output, WIDTH: operand A to the adder.
- `b_o`, output, WIDTH: operand B to the adder.
- `cin_o`, output, 1: carry-in to the adder.
- `sum_i`, input, WIDTH: adder sum.
- `cout_i`, input, 1: adder carry-out.
- `busy`, output, 1: high from start acceptance until `done`.
- `done`, output, 1: run complete. Held until the next accepted `start`.
- `pass`, output, 1: valid while `done`. High when `err_count` is 0.
- `err_count`, output, 16: mismatch count, saturating at 16'hFFFF.
- `fail_a`, `fail_b`, output, WIDTH each: operands of the first mismatch.
- `fail_cin`, output, 1: carry-in of the first mismatch.

## Operation

- **FSM states:** IDLE, CORNER, RANDOM, DRAIN, DONE.
- **IDLE → CORNER** on `start`. At acceptance:
  - clear `err_count` and the `fail_*` outputs;
  - clear the first-fail flag and `done`;
  - reload the LFSR with `SEED`.
- **CORNER:** issues 4 vectors, one per cycle, as (A, B, cin):
  - (0, 0, 0)
  - (all-ones, all-ones, 1)
  - (all-ones, 0, 1)
  - (0x5555… truncated to WIDTH, 0xAAAA… truncated to WIDTH, 1)
  - Then → RANDOM.
- **RANDOM:** issues `NUM_VECTORS` vectors, one per cycle.
  - Vector source: a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), advanced once per vector.
  - Operand mapping: A = lfsr[WIDTH-1:0], B = lfsr[31:32-WIDTH], cin = lfsr[16].
  - After the last vector → DRAIN.
- **DRAIN:** waits until every issued vector has been compared, then → DONE.
- **DONE → CORNER** on `start`. A new run starts with the same clearing as from IDLE.
- **Expected result:** the (WIDTH+1)-bit value {cout, sum} = A + B + cin. It is carried through a delay line of depth ADDER_LAT+1 together with a valid bit and the operands.
- **Mismatch handling:** any mismatch of {cout_i, sum_i} against the expected value:
  - increments `err_count` (saturating);
  - on the first mismatch of the run only, latches `fail_a`, `fail_b` and `fail_cin`.
- **Operand outputs when not issuing** (IDLE, DRAIN, DONE): `a_o`, `b_o` and `cin_o` hold 0.
- **Reset values:** all outputs 0; state IDLE; LFSR = SEED (or 1 if SEED is 0).
- **Reset mid-run:** asserting `rst_n` low aborts immediately. No result is reported; all outputs return to their reset values.

## Timing

- **Issue timing:**
  - `start` is sampled at edge e0.
  - `busy` is high and vector 0 is on `a_o`/`b_o` after e0.
  - Vector k is driven after edge e0+k.
- **Compare timing:** the response to vector k is sampled at edge e0+k+1+ADDER_LAT.
- **Total vectors:** V = 4 + NUM_VECTORS.
- **Final compare** at edge e0+V+ADDER_LAT.
- **Completion:** `done` and `pass` become valid, and `busy` falls, after edge e0+V+ADDER_LAT+1.
  - Defaults: e0+261.
- **First-fail priority:** if an `err_count` increment and a first-fail latch occur on the same edge, both take effect; the first-fail latch wins once per run.
- **Start during a run:** `start` while `busy` has no effect at all, including on the LFSR and counters.
- **No back-pressure:** the adder has a fixed latency, so one vector is issued every cycle.

## Structure

- **Shared package `ks_pkg`:**
  - FSM state enum;
  - LFSR polynomial mask;
  - corner-vector constants;
  - error-counter width (16).
- **Sub-module `ks_lfsr32`:** 32-bit Galois LFSR with ports `clk`, `rst_n`, `load`, `seed`, `step` and `q`. It has a seed-zero guard.
- **Everything else** (FSM, expected-value delay line, comparator and counters) lives in `ks_adder_bist`.

## Test plan

- **Fault-free, ADDER_LAT=0:** connect a correct adder model, WIDTH=16, NUM_VECTORS=256, pulse `start` → `busy` for 261 cycles, then `done`=1, `pass`=1, `err_count`=0.
- **Stuck-at fault:** model `sum_i[3]` stuck-at-0 → `pass`=0, `err_count` equals the reference count of vectors with true sum bit 3 = 1. `fail_a`/`fail_b`/`fail_cin` = (16'hFFFF, 16'hFFFF, 1), because corner vector 1 has sum 16'hFFFF.
- **Registered adder:** ADDER_LAT=2 with a 2-stage registered correct model → `pass`=1, `done` after 263 cycles. The same model with ADDER_LAT=0 → `pass`=0.
- **Start during a run:** pulse `start` at cycle 50 of a run → completion cycle and LFSR sequence are identical to an uninterrupted run.
- **Reset mid-run:** assert `rst_n` low at cycle 100 → all outputs 0 immediately. A new `start` reproduces the same vector sequence from corner vector 0.
- **Saturation:** inverting adder model, NUM_VECTORS=65535 → `err_count` saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/ks_pkg.sv
// ks_pkg: shared definitions for the Kogge-Stone adder BIST engine.
//   - FSM state encoding
//   - LFSR feedback mask and step / seed-guard helpers
//   - corner-vector constants and error-counter width
package ks_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CORNER = 3'd1,
        ST_RANDOM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } ks_state_t;

    // Galois form of x^32 + x^22 + x^2 + x + 1 (right-shifting).
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    localparam int ERR_W      = 16;
    localparam int NUM_CORNER = 4;

    // Alternating-bit corner patterns; truncated to the operand width at use.
    localparam logic [15:0] CORNER_ALT_A = 16'h5555;
    localparam logic [15:0] CORNER_ALT_B = 16'hAAAA;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

    // An all-zero state would lock the LFSR, so zero is mapped to one.
    function automatic logic [31:0] seed_guard(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/ks_lfsr32.sv
// ks_lfsr32: 32-bit Galois LFSR vector source.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (resets to RESET_SEED)
//   load       : reload from seed (takes priority over step)
//   seed       : reload value; zero is replaced by one
//   step       : advance one position
//   q          : current LFSR state
module ks_lfsr32
    import ks_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed_guard(seed);
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= seed_guard(RESET_SEED);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ks_adder_bist.sv
// ks_adder_bist: self-test engine for the Kogge-Stone adder macro.
// Issues 4 corner vectors then NUM_VECTORS LFSR vectors, one per cycle, and
// compares the adder's {cout, sum} against A + B + cin delayed to match the
// adder latency.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle run request (ignored while busy)
//   a_o, b_o, cin_o       : operands to the adder (0 when not issuing)
//   sum_i, cout_i         : adder result
//   busy, done, pass      : run status; pass valid while done
//   err_count             : saturating mismatch count
//   fail_a/fail_b/fail_cin: operands of the first mismatch of the run
//   dbg_state_o           : current FSM state encoding
// Handshake: start is a level sampled on the clock edge; it is accepted only
// in IDLE or DONE. There is no back-pressure: the adder has fixed latency.
module ks_adder_bist
    import ks_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          NUM_VECTORS = 256,
    parameter int          ADDER_LAT   = 0,
    parameter logic [31:0] SEED        = 32'hACE1_2024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [2:0]       dbg_state_o
);

    localparam logic [15:0] LAST_RND = 16'(NUM_VECTORS - 1);

    typedef struct packed {
        logic             valid;
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } chk_t;

    ks_state_t        state_q, state_d;
    logic [1:0]       corner_idx_q, corner_idx_d;
    logic [15:0]      rnd_cnt_q, rnd_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic             fail_cin_q, fail_cin_d;
    logic             first_q, first_d;

    logic             accept;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic [31:0]      lfsr_q;
    logic             pending;
    logic             mismatch;
    chk_t             cur;
    chk_t             cmp;

    ks_lfsr32 #(
        .RESET_SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (lfsr_load),
        .seed (SEED),
        .step (lfsr_adv),
        .q    (lfsr_q)
    );

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

    // Vector currently on the adder inputs, with its expected result.
    always_comb begin
        cur = '0;
        case (state_q)
            ST_CORNER: begin
                cur.valid = 1'b1;
                case (corner_idx_q)
                    2'd0: begin
                        cur.a   = '0;
                        cur.b   = '0;
                        cur.cin = 1'b0;
                    end
                    2'd1: begin
                        cur.a   = '1;
                        cur.b   = '1;
                        cur.cin = 1'b1;
                    end
                    2'd2: begin
                        cur.a   = '1;
                        cur.b   = '0;
                        cur.cin = 1'b1;
                    end
                    default: begin
                        cur.a   = CORNER_ALT_A[WIDTH-1:0];
                        cur.b   = CORNER_ALT_B[WIDTH-1:0];
                        cur.cin = 1'b1;
                    end
                endcase
            end
            ST_RANDOM: begin
                cur.valid = 1'b1;
                cur.a     = lfsr_q[WIDTH-1:0];
                cur.b     = lfsr_q[31 -: WIDTH];
                cur.cin   = lfsr_q[16];
            end
            default: ;
        endcase
        cur.exp = {1'b0, cur.a} + {1'b0, cur.b} + (WIDTH+1)'(cur.cin);
    end

    // Expected-value delay line: the adder response to a vector is sampled
    // ADDER_LAT edges after the edge that retires the vector from the inputs.
    generate
        if (ADDER_LAT == 0) begin : g_direct
            assign cmp     = cur;
            assign pending = 1'b0;
        end else begin : g_pipe
            chk_t pipe_q [ADDER_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < ADDER_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= cur;
                    for (int i = 1; i < ADDER_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            always_comb begin
                pending = 1'b0;
                for (int i = 0; i < ADDER_LAT; i++) begin
                    pending = pending | pipe_q[i].valid;
                end
            end

            assign cmp = pipe_q[ADDER_LAT-1];
        end
    endgenerate

    assign mismatch = cmp.valid && ({cout_i, sum_i} != cmp.exp);

    // FSM next state and vector sequencing.
    always_comb begin
        state_d      = state_q;
        corner_idx_d = corner_idx_q;
        rnd_cnt_d    = rnd_cnt_q;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_CORNER;
                    corner_idx_d = 2'd0;
                    rnd_cnt_d    = 16'd0;
                    lfsr_load    = 1'b1;
                end
            end
            ST_CORNER: begin
                if (corner_idx_q == 2'(NUM_CORNER - 1)) begin
                    state_d   = ST_RANDOM;
                    rnd_cnt_d = 16'd0;
                end else begin
                    corner_idx_d = corner_idx_q + 2'd1;
                end
            end
            ST_RANDOM: begin
                // The vector on the inputs uses the current LFSR state.
                lfsr_adv = 1'b1;
                if (rnd_cnt_q == LAST_RND) begin
                    state_d = ST_DRAIN;
                end else begin
                    rnd_cnt_d = rnd_cnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (!pending) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error counter and first-fail capture.
    always_comb begin
        err_d      = err_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_cin_d = fail_cin_q;
        first_d    = first_q;
        if (accept) begin
            err_d      = '0;
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_cin_d = 1'b0;
            first_d    = 1'b0;
        end else if (mismatch) begin
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!first_q) begin
                fail_a_d   = cmp.a;
                fail_b_d   = cmp.b;
                fail_cin_d = cmp.cin;
                first_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            corner_idx_q <= 2'd0;
            rnd_cnt_q    <= 16'd0;
            err_q        <= '0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_cin_q   <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            corner_idx_q <= corner_idx_d;
            rnd_cnt_q    <= rnd_cnt_d;
            err_q        <= err_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_cin_q   <= fail_cin_d;
            first_q      <= first_d;
        end
    end

    assign a_o         = cur.a;
    assign b_o         = cur.b;
    assign cin_o       = cur.cin;
    assign busy        = (state_q == ST_CORNER) || (state_q == ST_RANDOM) ||
                         (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign pass        = done && (err_q == '0);
    assign err_count   = err_q;
    assign fail_a      = fail_a_q;
    assign fail_b      = fail_b_q;
    assign fail_cin    = fail_cin_q;
    assign dbg_state_o = state_q;

endmodule
